// File: rtl/rob_pkg.sv
// Shared definitions for the multi-commit reorder buffer.
// Holds the buffer geometry, the derived tag/count widths, the tag type and
// next_tag(), which walks the tag ring 1..DEPTH-1 and skips the reserved
// "no tag" entry 0.
package rob_pkg;

    localparam int unsigned DEPTH    = 64;  // entries including reserved entry 0
    localparam int unsigned DP_W     = 2;   // dispatch slots per cycle
    localparam int unsigned NUM_FU   = 4;   // completion ports
    localparam int unsigned COMMIT_W = 2;   // commit slots per cycle
    localparam int unsigned ADDR_LEN = 32;  // PC width
    localparam int unsigned REG_SEL  = 5;   // logical register index width

    localparam int unsigned SEL   = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(COMMIT_W) + 1;

    typedef logic [SEL-1:0]   tag_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam tag_t FIRST_TAG = tag_t'(1);

    // Successor on the tag ring; DEPTH-1 wraps to 1 so entry 0 is never used.
    function automatic tag_t next_tag(tag_t tag);
        return (tag == tag_t'(DEPTH - 1)) ? FIRST_TAG : tag + tag_t'(1);
    endfunction

endpackage

// File: rtl/rob_multi_commit_if.sv
// Dispatch / completion / commit bundle of the reorder buffer.
// master: the pipeline side (drives flush, dispatch and completion,
//         observes the commit slots).
// slave:  the reorder buffer itself.
// Multi-slot fields are flat vectors; slot k occupies [k*W +: W].
interface rob_multi_commit_if;
    import rob_pkg::*;

    logic                         flush_i;
    logic [DP_W-1:0]              dp_i;
    logic [DP_W*SEL-1:0]          dp_addr_i;
    logic [DP_W*ADDR_LEN-1:0]     dp_pc_i;
    logic [DP_W-1:0]              dp_dstvalid_i;
    logic [DP_W*REG_SEL-1:0]      dp_dst_i;
    logic [NUM_FU-1:0]            fin_i;
    logic [NUM_FU*SEL-1:0]        fin_addr_i;
    logic [SEL-1:0]               commit_ptr_o;
    logic [COMMIT_W-1:0]          commit_o;
    logic [COMMIT_W-1:0]          arfwe_o;
    logic [COMMIT_W*REG_SEL-1:0]  dst_arf_o;
    logic [COMMIT_W*ADDR_LEN-1:0] pc_com_o;
    logic [CNT_W-1:0]             comnum_o;

    modport master (
        output flush_i, dp_i, dp_addr_i, dp_pc_i, dp_dstvalid_i, dp_dst_i, fin_i, fin_addr_i,
        input  commit_ptr_o, commit_o, arfwe_o, dst_arf_o, pc_com_o, comnum_o
    );

    modport slave (
        input  flush_i, dp_i, dp_addr_i, dp_pc_i, dp_dstvalid_i, dp_dst_i, fin_i, fin_addr_i,
        output commit_ptr_o, commit_o, arfwe_o, dst_arf_o, pc_com_o, comnum_o
    );

endinterface

// File: rtl/rob_tag_inc.sv
// Tag ring walker.
// Ports:
//   ptr      in   starting tag (commit pointer)
//   cnt      in   number of steps to advance (0..COMMIT_W)
//   slot_tag out  tags ptr, next(ptr), ... for the COMMIT_W commit slots
//   ptr_adv  out  ptr advanced cnt steps along the ring
// slot_tag does not depend on cnt, so a caller may derive cnt from slot_tag
// without forming a combinational loop.
module rob_tag_inc
    import rob_pkg::*;
(
    input  tag_t ptr,
    input  cnt_t cnt,
    output tag_t slot_tag [COMMIT_W],
    output tag_t ptr_adv
);

    tag_t chain [COMMIT_W+1];

    always_comb begin
        chain[0] = ptr;
        for (int k = 1; k <= COMMIT_W; k++) begin
            chain[k] = next_tag(chain[k-1]);
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_tag[k] = chain[k];
        end
    end

    always_comb begin
        ptr_adv = ptr;
        for (int k = 0; k <= COMMIT_W; k++) begin
            if (cnt == cnt_t'(k)) begin
                ptr_adv = chain[k];
            end
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// Multi-commit reorder buffer.
// Ports:
//   clk_i    in  clock, all state updates on the rising edge
//   reset_i  in  synchronous active-high reset
//   bus      slave modport of rob_multi_commit_if: flush, DP_W dispatch
//            slots, NUM_FU completion ports, COMMIT_W in-order commit slots
// Commit outputs are decoded purely from registered state; no input reaches
// an output in the same cycle. Per-entry update priority, high to low:
// reset, flush, dispatch, completion, commit-clear.
module rob_multi_commit
    import rob_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    rob_multi_commit_if.slave   bus
);

    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    finish_q, finish_d;
    logic [DEPTH-1:0]    dstvalid_q, dstvalid_d;
    logic [ADDR_LEN-1:0] pc_q [DEPTH];
    logic [REG_SEL-1:0]  dst_q [DEPTH];

    tag_t ptr_q, ptr_d, ptr_adv;
    tag_t slot_tag [COMMIT_W];

    logic [COMMIT_W-1:0]          commit, arfwe;
    logic [COMMIT_W*REG_SEL-1:0]  dst_arf;
    logic [COMMIT_W*ADDR_LEN-1:0] pc_com;
    cnt_t                         comnum;

    logic [DEPTH-1:0] fin_hit, com_hit;

    rob_tag_inc u_tag_inc (
        .ptr      (ptr_q),
        .cnt      (comnum),
        .slot_tag (slot_tag),
        .ptr_adv  (ptr_adv)
    );

    // In-order commit: a slot commits only if every older slot commits too.
    always_comb begin
        logic run;
        run     = 1'b1;
        commit  = '0;
        arfwe   = '0;
        dst_arf = '0;
        pc_com  = '0;
        comnum  = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            run       = run & valid_q[slot_tag[k]] & finish_q[slot_tag[k]];
            commit[k] = run;
            arfwe[k]  = run & dstvalid_q[slot_tag[k]];
            dst_arf[k*REG_SEL +: REG_SEL]   = dst_q[slot_tag[k]];
            pc_com[k*ADDR_LEN +: ADDR_LEN]  = pc_q[slot_tag[k]];
            if (run) begin
                comnum = comnum + cnt_t'(1);
            end
        end
    end

    assign bus.commit_ptr_o = ptr_q;
    assign bus.commit_o     = commit;
    assign bus.arfwe_o      = arfwe;
    assign bus.dst_arf_o    = dst_arf;
    assign bus.pc_com_o     = pc_com;
    assign bus.comnum_o     = comnum;

    // Next-state of the status bits; ordering of the assignments below
    // implements the priority (later assignments win).
    always_comb begin
        fin_hit = '0;
        com_hit = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (bus.fin_i[f]) begin
                fin_hit[bus.fin_addr_i[f*SEL +: SEL]] = 1'b1;
            end
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            if (commit[k]) begin
                com_hit[slot_tag[k]] = 1'b1;
            end
        end

        valid_d    = valid_q & ~com_hit;
        finish_d   = finish_q | fin_hit;
        dstvalid_d = dstvalid_q;
        ptr_d      = ptr_adv;

        for (int j = 0; j < DP_W; j++) begin
            if (bus.dp_i[j]) begin
                valid_d[bus.dp_addr_i[j*SEL +: SEL]]    = 1'b1;
                finish_d[bus.dp_addr_i[j*SEL +: SEL]]   = 1'b0;
                dstvalid_d[bus.dp_addr_i[j*SEL +: SEL]] = bus.dp_dstvalid_i[j];
            end
        end

        // Entry 0 is the "no tag" value and must never look live.
        valid_d[0]    = 1'b0;
        finish_d[0]   = 1'b0;
        dstvalid_d[0] = 1'b0;

        if (bus.flush_i) begin
            valid_d  = '0;
            finish_d = '0;
            ptr_d    = FIRST_TAG;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q      <= FIRST_TAG;
            valid_q    <= '0;
            finish_q   <= '0;
            dstvalid_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            finish_q   <= finish_d;
            dstvalid_q <= dstvalid_d;
        end
    end

    // Payload arrays are not reset; they are only meaningful while valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i && !bus.flush_i) begin
            for (int j = 0; j < DP_W; j++) begin
                if (bus.dp_i[j]) begin
                    pc_q[bus.dp_addr_i[j*SEL +: SEL]]  <= bus.dp_pc_i[j*ADDR_LEN +: ADDR_LEN];
                    dst_q[bus.dp_addr_i[j*SEL +: SEL]] <= bus.dp_dst_i[j*REG_SEL +: REG_SEL];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Self-checking bench for rob_multi_commit: directed scenarios plus a
// randomized run, all compared against a ring-arithmetic reference model.
module tb_rob_multi_commit;
    import rob_pkg::*;

    logic clk_i = 1'b0;
    logic reset_i;

    rob_multi_commit_if bus ();

    rob_multi_commit dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit                  m_valid [DEPTH];
    bit                  m_fin   [DEPTH];
    bit                  m_dv    [DEPTH];
    logic [ADDR_LEN-1:0] m_pc    [DEPTH];
    logic [REG_SEL-1:0]  m_dst   [DEPTH];
    int                  m_ptr;

    logic [COMMIT_W-1:0] exp_commit, exp_arfwe;
    logic [ADDR_LEN-1:0] exp_pc  [COMMIT_W];
    logic [REG_SEL-1:0]  exp_dst [COMMIT_W];
    int                  exp_n;

    // Ring of usable tags is 1..DEPTH-1; step n positions forward.
    function automatic int adv(int t, int n);
        return ((t - 1 + n) % int'(DEPTH - 1)) + 1;
    endfunction

    task automatic model_eval();
        int t;
        bit run;
        t = m_ptr;
        run = 1'b1;
        exp_commit = '0;
        exp_arfwe = '0;
        exp_n = 0;
        for (int k = 0; k < COMMIT_W; k++) begin
            exp_pc[k] = '0;
            exp_dst[k] = '0;
            if (run && m_valid[t] && m_fin[t]) begin
                exp_commit[k] = 1'b1;
                exp_arfwe[k] = m_dv[t];
                exp_pc[k] = m_pc[t];
                exp_dst[k] = m_dst[t];
                exp_n++;
            end else begin
                run = 1'b0;
            end
            t = adv(t, 1);
        end
    endtask

    // One clock edge: model consumes the currently driven inputs.
    task automatic tick();
        model_eval();
        @(posedge clk_i);
        if (reset_i) begin
            for (int e = 0; e < DEPTH; e++) begin
                m_valid[e] = 0; m_fin[e] = 0; m_dv[e] = 0;
            end
            m_ptr = 1;
        end else if (bus.flush_i) begin
            for (int e = 0; e < DEPTH; e++) begin
                m_valid[e] = 0; m_fin[e] = 0;
            end
            m_ptr = 1;
        end else begin
            for (int k = 0; k < exp_n; k++) m_valid[adv(m_ptr, k)] = 0;
            m_ptr = adv(m_ptr, exp_n);
            for (int f = 0; f < NUM_FU; f++) begin
                if (bus.fin_i[f]) m_fin[int'(bus.fin_addr_i[f*SEL +: SEL])] = 1;
            end
            for (int j = 0; j < DP_W; j++) begin
                if (bus.dp_i[j]) begin
                    int a;
                    a = int'(bus.dp_addr_i[j*SEL +: SEL]);
                    m_valid[a] = 1;
                    m_fin[a] = 0;
                    m_dv[a] = bus.dp_dstvalid_i[j];
                    m_pc[a] = bus.dp_pc_i[j*ADDR_LEN +: ADDR_LEN];
                    m_dst[a] = bus.dp_dst_i[j*REG_SEL +: REG_SEL];
                end
            end
        end
        #1;
        model_eval();
    endtask

    task automatic clear_inputs();
        bus.flush_i = 0;
        bus.dp_i = '0;
        bus.dp_addr_i = '0;
        bus.dp_pc_i = '0;
        bus.dp_dstvalid_i = '0;
        bus.dp_dst_i = '0;
        bus.fin_i = '0;
        bus.fin_addr_i = '0;
    endtask

    task automatic drive_dp(input int j, input int tag, input logic [ADDR_LEN-1:0] pc,
                            input logic [REG_SEL-1:0] dst, input bit dv);
        bus.dp_i[j] = 1'b1;
        bus.dp_addr_i[j*SEL +: SEL] = tag_t'(tag);
        bus.dp_pc_i[j*ADDR_LEN +: ADDR_LEN] = pc;
        bus.dp_dst_i[j*REG_SEL +: REG_SEL] = dst;
        bus.dp_dstvalid_i[j] = dv;
    endtask

    task automatic drive_fin(input int f, input int tag);
        bus.fin_i[f] = 1'b1;
        bus.fin_addr_i[f*SEL +: SEL] = tag_t'(tag);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.commit_ptr_o !== tag_t'(1)) begin
            errors++; $display("FAIL reset_ptr: got %0d expected 1", bus.commit_ptr_o); end
        checks++; if (bus.commit_o !== '0) begin
            errors++; $display("FAIL reset_commit: got %b expected 0", bus.commit_o); end
        checks++; if (bus.arfwe_o !== '0) begin
            errors++; $display("FAIL reset_arfwe: got %b expected 0", bus.arfwe_o); end
        checks++; if (bus.comnum_o !== '0) begin
            errors++; $display("FAIL reset_comnum: got %0d expected 0", bus.comnum_o); end
    endtask

    task automatic test_single_commit();
        do_reset();
        drive_dp(0, 1, 32'h100, 5'd5, 1'b1);
        tick();
        clear_inputs();
        drive_fin(0, 1);
        tick();
        clear_inputs();
        checks++; if (bus.commit_o !== 2'b01) begin
            errors++; $display("FAIL single_commit: got %b expected 01", bus.commit_o); end
        checks++; if (bus.arfwe_o !== 2'b01) begin
            errors++; $display("FAIL single_arfwe: got %b expected 01", bus.arfwe_o); end
        checks++; if (bus.dst_arf_o[REG_SEL-1:0] !== 5'd5) begin
            errors++; $display("FAIL single_dst: got %0d expected 5", bus.dst_arf_o[REG_SEL-1:0]); end
        checks++; if (bus.pc_com_o[ADDR_LEN-1:0] !== 32'h100) begin
            errors++; $display("FAIL single_pc: got %h expected 100", bus.pc_com_o[ADDR_LEN-1:0]); end
        checks++; if (bus.comnum_o !== cnt_t'(1)) begin
            errors++; $display("FAIL single_comnum: got %0d expected 1", bus.comnum_o); end
        tick();
        checks++; if (bus.commit_ptr_o !== tag_t'(2)) begin
            errors++; $display("FAIL single_ptr: got %0d expected 2", bus.commit_ptr_o); end
        checks++; if (bus.commit_o !== 2'b00) begin
            errors++; $display("FAIL single_after: got %b expected 00", bus.commit_o); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        drive_dp(0, 1, 32'h200, 5'd1, 1'b1);
        drive_dp(1, 2, 32'h204, 5'd2, 1'b1);
        tick();
        clear_inputs();
        drive_fin(0, 2);
        tick();
        clear_inputs();
        checks++; if (bus.commit_o !== 2'b00) begin
            errors++; $display("FAIL ooo_blocked: got %b expected 00", bus.commit_o); end
        drive_fin(0, 1);
        tick();
        clear_inputs();
        checks++; if (bus.commit_o !== 2'b11) begin
            errors++; $display("FAIL ooo_commit: got %b expected 11", bus.commit_o); end
        checks++; if (bus.comnum_o !== cnt_t'(2)) begin
            errors++; $display("FAIL ooo_comnum: got %0d expected 2", bus.comnum_o); end
        checks++; if (bus.pc_com_o[ADDR_LEN +: ADDR_LEN] !== 32'h204) begin
            errors++; $display("FAIL ooo_pc1: got %h expected 204",
                               bus.pc_com_o[ADDR_LEN +: ADDR_LEN]); end
        tick();
        checks++; if (bus.commit_ptr_o !== tag_t'(3)) begin
            errors++; $display("FAIL ooo_ptr: got %0d expected 3", bus.commit_ptr_o); end
    endtask

    task automatic test_no_dst();
        do_reset();
        drive_dp(0, 1, 32'h300, 5'd7, 1'b0);
        tick();
        clear_inputs();
        drive_fin(0, 1);
        tick();
        clear_inputs();
        checks++; if (bus.commit_o[0] !== 1'b1) begin
            errors++; $display("FAIL nodst_commit: got %b expected 1", bus.commit_o[0]); end
        checks++; if (bus.arfwe_o[0] !== 1'b0) begin
            errors++; $display("FAIL nodst_arfwe: got %b expected 0", bus.arfwe_o[0]); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int t = 1; t <= 61; t += 2) begin
            clear_inputs();
            drive_dp(0, t, 32'h1000 + t * 4, 5'(t), 1'b1);
            if (t + 1 <= 61) drive_dp(1, t + 1, 32'h1000 + (t + 1) * 4, 5'(t + 1), 1'b1);
            tick();
        end
        for (int t = 1; t <= 61; t += 4) begin
            clear_inputs();
            for (int f = 0; f < NUM_FU; f++) if (t + f <= 61) drive_fin(f, t + f);
            tick();
        end
        clear_inputs();
        for (int i = 0; i < 80 && bus.commit_ptr_o !== tag_t'(62); i++) begin
            checks++; if (bus.comnum_o !== cnt_t'(exp_n) || bus.commit_ptr_o === '0) begin
                errors++; $display("FAIL wrap_drain: comnum %0d expected %0d ptr %0d",
                                   bus.comnum_o, exp_n, bus.commit_ptr_o); end
            tick();
        end
        checks++; if (bus.commit_ptr_o !== tag_t'(62)) begin
            errors++; $display("FAIL wrap_reach62: got %0d expected 62", bus.commit_ptr_o); end
        drive_dp(0, 62, 32'hAAAA_0062, 5'd10, 1'b1);
        drive_dp(1, 63, 32'hAAAA_0063, 5'd11, 1'b1);
        tick();
        clear_inputs();
        drive_fin(0, 62);
        drive_fin(1, 63);
        tick();
        clear_inputs();
        checks++; if (bus.commit_o !== 2'b11 || bus.comnum_o !== cnt_t'(2)) begin
            errors++; $display("FAIL wrap_commit: got %b/%0d expected 11/2",
                               bus.commit_o, bus.comnum_o); end
        checks++; if (bus.pc_com_o !== {32'hAAAA_0063, 32'hAAAA_0062}) begin
            errors++; $display("FAIL wrap_pc: got %h expected aaaa0063aaaa0062", bus.pc_com_o); end
        tick();
        checks++; if (bus.commit_ptr_o !== tag_t'(1)) begin
            errors++; $display("FAIL wrap_ptr: got %0d expected 1", bus.commit_ptr_o); end
        checks++; if (bus.commit_o !== 2'b00) begin
            errors++; $display("FAIL wrap_after: got %b expected 00", bus.commit_o); end
    endtask

    task automatic test_four_fu();
        do_reset();
        drive_dp(0, 1, 32'h10, 5'd1, 1'b1);
        drive_dp(1, 2, 32'h14, 5'd2, 1'b1);
        tick();
        clear_inputs();
        drive_fin(0, 1);
        drive_fin(1, 2);
        tick();
        clear_inputs();
        tick();
        checks++; if (bus.commit_ptr_o !== tag_t'(3)) begin
            errors++; $display("FAIL fu_ptr3: got %0d expected 3", bus.commit_ptr_o); end
        drive_dp(0, 3, 32'h30, 5'd3, 1'b1);
        drive_dp(1, 4, 32'h40, 5'd4, 1'b0);
        tick();
        clear_inputs();
        drive_dp(0, 5, 32'h50, 5'd5, 1'b1);
        drive_dp(1, 6, 32'h60, 5'd6, 1'b1);
        tick();
        clear_inputs();
        for (int f = 0; f < NUM_FU; f++) drive_fin(f, 3 + f);
        tick();
        clear_inputs();
        checks++; if (bus.commit_o !== 2'b11 || bus.pc_com_o !== {32'h40, 32'h30}) begin
            errors++; $display("FAIL fu_first: got %b pc %h expected 11 pc 4030",
                               bus.commit_o, bus.pc_com_o); end
        checks++; if (bus.arfwe_o !== 2'b01) begin
            errors++; $display("FAIL fu_arfwe: got %b expected 01", bus.arfwe_o); end
        tick();
        checks++; if (bus.commit_o !== 2'b11 || bus.pc_com_o !== {32'h60, 32'h50}) begin
            errors++; $display("FAIL fu_second: got %b pc %h expected 11 pc 6050",
                               bus.commit_o, bus.pc_com_o); end
        tick();
        checks++; if (bus.commit_ptr_o !== tag_t'(7) || bus.commit_o !== 2'b00) begin
            errors++; $display("FAIL fu_end: ptr %0d commit %b expected 7 00",
                               bus.commit_ptr_o, bus.commit_o); end
    endtask

    task automatic test_flush();
        do_reset();
        drive_dp(0, 1, 32'h500, 5'd1, 1'b1);
        drive_dp(1, 2, 32'h504, 5'd2, 1'b1);
        tick();
        clear_inputs();
        drive_dp(0, 3, 32'h508, 5'd3, 1'b1);
        tick();
        clear_inputs();
        bus.flush_i = 1'b1;
        drive_dp(0, 1, 32'h600, 5'd9, 1'b1);
        for (int f = 0; f < 3; f++) drive_fin(f, 1 + f);
        tick();
        clear_inputs();
        checks++; if (bus.commit_ptr_o !== tag_t'(1) || bus.commit_o !== 2'b00) begin
            errors++; $display("FAIL flush_state: ptr %0d commit %b expected 1 00",
                               bus.commit_ptr_o, bus.commit_o); end
        drive_fin(0, 1);
        tick();
        clear_inputs();
        checks++; if (bus.commit_o !== 2'b00) begin
            errors++; $display("FAIL flush_dropped_dp: got %b expected 00", bus.commit_o); end
        // Commit already visible in the flush cycle still drives the outputs.
        drive_dp(0, 1, 32'h700, 5'd4, 1'b1);
        tick();
        clear_inputs();
        drive_fin(0, 1);
        tick();
        clear_inputs();
        bus.flush_i = 1'b1;
        #1;
        checks++; if (bus.commit_o !== 2'b01 || bus.pc_com_o[ADDR_LEN-1:0] !== 32'h700) begin
            errors++; $display("FAIL flush_cycle_commit: got %b pc %h expected 01 pc 700",
                               bus.commit_o, bus.pc_com_o[ADDR_LEN-1:0]); end
        tick();
        clear_inputs();
        checks++; if (bus.commit_ptr_o !== tag_t'(1)) begin
            errors++; $display("FAIL flush_ptr: got %0d expected 1", bus.commit_ptr_o); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int cnt, tail, ndp;
            clear_inputs();
            if ($urandom_range(0, 599) == 0) reset_i = 1'b1;
            else if ($urandom_range(0, 79) == 0) bus.flush_i = 1'b1;
            cnt = 0;
            for (int e = 1; e < DEPTH; e++) cnt += int'(m_valid[e]);
            tail = adv(m_ptr, cnt);
            ndp = int'($urandom_range(0, DP_W));
            if (ndp > DEPTH - 1 - cnt) ndp = DEPTH - 1 - cnt;
            for (int j = 0; j < ndp; j++) begin
                drive_dp(j, adv(tail, j), $urandom, 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)));
            end
            for (int f = 0; f < NUM_FU; f++) begin
                if (cnt > 0 && $urandom_range(0, 2) != 0)
                    drive_fin(f, adv(m_ptr, int'($urandom_range(0, cnt - 1))));
            end
            tick();
            reset_i = 1'b0;
            checks++; if (bus.commit_o !== exp_commit || bus.arfwe_o !== exp_arfwe) begin
                errors++; $display("FAIL rnd_commit cyc %0d: got %b/%b expected %b/%b", cyc,
                                   bus.commit_o, bus.arfwe_o, exp_commit, exp_arfwe); end
            checks++; if (bus.comnum_o !== cnt_t'(exp_n)) begin
                errors++; $display("FAIL rnd_comnum cyc %0d: got %0d expected %0d", cyc,
                                   bus.comnum_o, exp_n); end
            checks++; if (bus.commit_ptr_o !== tag_t'(m_ptr)) begin
                errors++; $display("FAIL rnd_ptr cyc %0d: got %0d expected %0d", cyc,
                                   bus.commit_ptr_o, m_ptr); end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (exp_commit[k]) begin
                    checks++;
                    if (bus.pc_com_o[k*ADDR_LEN +: ADDR_LEN] !== exp_pc[k] ||
                        bus.dst_arf_o[k*REG_SEL +: REG_SEL] !== exp_dst[k]) begin
                        errors++;
                        $display("FAIL rnd_data cyc %0d slot %0d: got %h/%0d expected %h/%0d",
                                 cyc, k, bus.pc_com_o[k*ADDR_LEN +: ADDR_LEN],
                                 bus.dst_arf_o[k*REG_SEL +: REG_SEL], exp_pc[k], exp_dst[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        m_ptr = 1;
        reset_i = 1'b1;
        clear_inputs();
        test_reset();
        test_single_commit();
        test_out_of_order();
        test_no_dst();
        test_wrap();
        test_four_fu();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
